// File: rtl/freq_count_pkg.sv
// Shared constants, state encoding and error codes for the frequency-counter
// Wishbone master and its single-transfer engine.
package freq_count_pkg;

  localparam logic [31:0] DEF_ADDR_CTRL   = 32'h8;
  localparam logic [31:0] DEF_ADDR_RESULT = 32'h9;

  localparam int CTRL_RST   = 0;
  localparam int CTRL_START = 7;

  typedef enum logic [2:0] {
    IDLE,
    WR_RST,
    GAP1,
    WR_START,
    GAP2,
    WAIT_GATE,
    RD_RES,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_BUS     = 2'b01,
    ERR_RETRY   = 2'b10,
    ERR_TIMEOUT = 2'b11
  } err_e;

  function automatic logic [31:0] ctrl_word(input int bit_pos);
    return 32'(1) << bit_pos;
  endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic single transfer: registered bus drive, retry reissue
// and per-attempt timeout. Completion is reported combinationally at the
// edge that registers the slave termination.
module wb_single_xfer
  import freq_count_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic        req_we,
  output logic        fin,
  output logic [1:0]  fin_err,
  output logic [31:0] rdata,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [3:0]  sel_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int RTRY_W = $clog2(MAX_RETRY + 2);

  logic [WAIT_W-1:0] wait_cnt;
  logic [RTRY_W-1:0] rtry_cnt;
  logic              reissue;
  logic              exhausted;
  logic              timed_out;

  assign exhausted = (rtry_cnt == RTRY_W'(MAX_RETRY));
  assign timed_out = !(ack_i || err_i || rty_i) && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign rdata     = dat_i;

  // err beats rty beats ack; a plain rty only ends the transfer once exhausted
  always_comb begin
    fin     = 1'b0;
    fin_err = ERR_OK;
    if (stb_o) begin
      if (err_i) begin
        fin     = 1'b1;
        fin_err = ERR_BUS;
      end else if (rty_i) begin
        if (exhausted) begin
          fin     = 1'b1;
          fin_err = ERR_RETRY;
        end
      end else if (ack_i) begin
        fin = 1'b1;
      end else if (timed_out) begin
        fin     = 1'b1;
        fin_err = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_o    <= 1'b0;
      cyc_o    <= 1'b0;
      sel_o    <= 4'h0;
      we_o     <= 1'b0;
      adr_o    <= 32'h0;
      dat_o    <= 32'h0;
      reissue  <= 1'b0;
      wait_cnt <= '0;
      rtry_cnt <= '0;
    end else if (req) begin
      stb_o    <= 1'b1;
      cyc_o    <= 1'b1;
      sel_o    <= 4'hF;
      we_o     <= req_we;
      adr_o    <= req_adr;
      dat_o    <= req_dat;
      reissue  <= 1'b0;
      wait_cnt <= '0;
      rtry_cnt <= '0;
    end else if (reissue) begin
      // address, data and we are still held from the original request
      stb_o    <= 1'b1;
      cyc_o    <= 1'b1;
      sel_o    <= 4'hF;
      reissue  <= 1'b0;
      wait_cnt <= '0;
    end else if (stb_o) begin
      if (fin) begin
        stb_o <= 1'b0;
        cyc_o <= 1'b0;
        sel_o <= 4'h0;
      end else if (rty_i) begin
        stb_o    <= 1'b0;
        cyc_o    <= 1'b0;
        sel_o    <= 4'h0;
        reissue  <= 1'b1;
        rtry_cnt <= rtry_cnt + 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_count_wb_master.sv
// Sequences one frequency_counter measurement over Wishbone: reset write,
// start write, programmable gate wait, then result read.
module freq_count_wb_master
  import freq_count_pkg::*;
#(
  parameter logic [31:0] ADDR_CTRL   = DEF_ADDR_CTRL,
  parameter logic [31:0] ADDR_RESULT = DEF_ADDR_RESULT,
  parameter int          GATE_W      = 16,
  parameter int          TIMEOUT     = 16,
  parameter int          MAX_RETRY   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [GATE_W-1:0] gate_cycles_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       result_o,
  output logic [1:0]        error_o,
  output logic [31:0]       adr_o,
  output logic [31:0]       dat_o,
  input  logic [31:0]       dat_i,
  output logic              we_o,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              lock_o,
  output logic [3:0]        sel_o,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic              rty_i,
  output logic              tagn_o
);

  state_e            state, state_n;
  logic [GATE_W-1:0] gate_q, gate_n;
  logic [GATE_W-1:0] gate_cnt, cnt_n;
  logic [31:0]       result_n;
  logic [1:0]        error_n;
  logic              done_n;

  logic              req;
  logic [31:0]       req_adr;
  logic [31:0]       req_dat;
  logic              req_we;
  logic              x_fin;
  logic [1:0]        x_err;
  logic [31:0]       x_rdata;

  assign lock_o = 1'b0;
  assign tagn_o = 1'b0;

  wb_single_xfer #(
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) u_xfer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (req),
    .req_adr (req_adr),
    .req_dat (req_dat),
    .req_we  (req_we),
    .fin     (x_fin),
    .fin_err (x_err),
    .rdata   (x_rdata),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .dat_i   (dat_i),
    .we_o    (we_o),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .sel_o   (sel_o),
    .ack_i   (ack_i),
    .err_i   (err_i),
    .rty_i   (rty_i)
  );

  // Requests are raised in the cycle before a transfer state so the
  // transfer engine registers stb_o on the same edge the state is entered.
  always_comb begin
    state_n  = state;
    gate_n   = gate_q;
    cnt_n    = gate_cnt;
    result_n = result_o;
    error_n  = error_o;
    done_n   = 1'b0;
    req      = 1'b0;
    req_adr  = ADDR_CTRL;
    req_dat  = 32'h0;
    req_we   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_n = WR_RST;
          gate_n  = gate_cycles_i;
          error_n = ERR_OK;
          req     = 1'b1;
          req_adr = ADDR_CTRL;
          req_dat = ctrl_word(CTRL_RST);
          req_we  = 1'b1;
        end
      end
      WR_RST: begin
        if (x_fin) begin
          if (x_err != ERR_OK) begin
            error_n = x_err;
            state_n = FINISH;
            done_n  = 1'b1;
          end else begin
            state_n = GAP1;
          end
        end
      end
      GAP1: begin
        state_n = WR_START;
        req     = 1'b1;
        req_adr = ADDR_CTRL;
        req_dat = ctrl_word(CTRL_START);
        req_we  = 1'b1;
      end
      WR_START: begin
        if (x_fin) begin
          if (x_err != ERR_OK) begin
            error_n = x_err;
            state_n = FINISH;
            done_n  = 1'b1;
          end else begin
            state_n = GAP2;
          end
        end
      end
      GAP2: begin
        state_n = WAIT_GATE;
        cnt_n   = gate_q;
      end
      WAIT_GATE: begin
        if (gate_cnt == '0) begin
          state_n = RD_RES;
          req     = 1'b1;
          req_adr = ADDR_RESULT;
          req_we  = 1'b0;
        end else begin
          cnt_n = gate_cnt - 1'b1;
        end
      end
      RD_RES: begin
        if (x_fin) begin
          if (x_err != ERR_OK) begin
            error_n = x_err;
          end else begin
            result_n = x_rdata;
          end
          state_n = FINISH;
          done_n  = 1'b1;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      result_o <= 32'h0;
      error_o  <= 2'b00;
      done_o   <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_n;
      result_o <= result_n;
      error_o  <= error_n;
      done_o   <= done_n;
      busy_o   <= (state_n != IDLE);
    end
  end

  // gate value and countdown are only read after being loaded
  always_ff @(posedge clk_i) begin
    gate_q   <= gate_n;
    gate_cnt <= cnt_n;
  end

endmodule

// File: tb/tb_freq_count_wb_master.sv
// Bench for freq_count_wb_master: scripted Wishbone slave plus a
// cycle-cost reference model of one measurement.
module tb_freq_count_wb_master;

  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 3;
  localparam int GATE_W    = 16;

  localparam int R_ACK    = 0;
  localparam int R_ERR    = 1;
  localparam int R_ERRACK = 2;
  localparam int R_NONE   = 3;
  localparam int R_RTY    = 4;

  typedef logic [64:0] val_t;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [GATE_W-1:0] gate_cycles_i;
  logic              busy_o, done_o;
  logic [31:0]       result_o;
  logic [1:0]        error_o;
  logic [31:0]       adr_o, dat_o, dat_i;
  logic              we_o, cyc_o, stb_o, lock_o, tagn_o;
  logic [3:0]        sel_o;
  logic              ack_i, err_i, rty_i;

  always #5 clk = ~clk;

  freq_count_wb_master #(
    .ADDR_CTRL   (32'h8),
    .ADDR_RESULT (32'h9),
    .GATE_W      (GATE_W),
    .TIMEOUT     (TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .gate_cycles_i (gate_cycles_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .result_o      (result_o),
    .error_o       (error_o),
    .adr_o         (adr_o),
    .dat_o         (dat_o),
    .dat_i         (dat_i),
    .we_o          (we_o),
    .cyc_o         (cyc_o),
    .stb_o         (stb_o),
    .lock_o        (lock_o),
    .sel_o         (sel_o),
    .ack_i         (ack_i),
    .err_i         (err_i),
    .rty_i         (rty_i),
    .tagn_o        (tagn_o)
  );

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_checks = 0;
  int n_errors = 0;

  // slave script, one entry per transfer (0 reset write, 1 start write, 2 read)
  int          n_rty [3];
  int          wt    [3];
  int          fin   [3];
  logic [31:0] rdata;

  int          att [3];
  int          wcnt;
  logic        prev_stb;
  bit          done_seen;
  int unsigned done_cyc;
  int          done_cnt;
  int          proto_bad;
  val_t        obs   [$];
  val_t        exp_q [$];
  int          exp_total;
  logic [1:0]  exp_err;
  logic [31:0] exp_result;
  int unsigned e0;

  task automatic chk(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock: observe at the falling edge, then drive the slave response
  task automatic step();
    int tid;
    @(negedge clk);
    if (done_o) begin
      done_seen = 1'b1;
      done_cyc  = cyc_n;
      done_cnt++;
    end
    if ((cyc_o !== stb_o) || lock_o || tagn_o ||
        (stb_o && sel_o != 4'hF) || (!stb_o && sel_o != 4'h0))
      proto_bad++;
    ack_i = 1'b0;
    err_i = 1'b0;
    rty_i = 1'b0;
    dat_i = $urandom;
    if (stb_o) begin
      tid = (adr_o == 32'h9) ? 2 : ((dat_o == 32'h80) ? 1 : 0);
      if (!prev_stb) begin
        att[tid]++;
        wcnt = 0;
        obs.push_back({we_o, adr_o, (we_o ? dat_o : 32'h0)});
      end else begin
        wcnt++;
      end
      if (wcnt == wt[tid]) begin
        if (att[tid] <= n_rty[tid]) rty_i = 1'b1;
        else begin
          case (fin[tid])
            R_ACK:    ack_i = 1'b1;
            R_ERR:    err_i = 1'b1;
            R_ERRACK: begin err_i = 1'b1; ack_i = 1'b1; end
            default:  ;
          endcase
        end
        if (tid == 2) dat_i = rdata;
      end
    end
    prev_stb = stb_o;
  endtask

  // Cost model: an attempt answered after w wait cycles costs w+1 cycles,
  // a retry adds one idle cycle, silence costs TIMEOUT cycles.
  task automatic model(input int g);
    val_t desc [3];
    bit   stop;
    int   resp;
    desc[0] = {1'b1, 32'h8, 32'h1};
    desc[1] = {1'b1, 32'h8, 32'h80};
    desc[2] = {1'b0, 32'h9, 32'h0};
    stop = 1'b0;
    exp_q.delete();
    exp_total = 0;
    exp_err   = 2'b00;
    for (int t = 0; t < 3 && !stop; t++) begin
      for (int a = 0; a <= MAX_RETRY; a++) begin
        exp_q.push_back(desc[t]);
        resp = (a < n_rty[t]) ? R_RTY : fin[t];
        if (wt[t] >= TIMEOUT || resp == R_NONE) begin
          exp_total += TIMEOUT; exp_err = 2'b11; stop = 1'b1; break;
        end
        exp_total += wt[t] + 1;
        if (resp == R_ERR || resp == R_ERRACK) begin
          exp_err = 2'b01; stop = 1'b1; break;
        end
        if (resp == R_RTY) begin
          if (a == MAX_RETRY) begin exp_err = 2'b10; stop = 1'b1; break; end
          exp_total += 1;
        end else begin
          break;
        end
      end
      if (!stop) begin
        if (t < 2)  exp_total += 1;
        if (t == 1) exp_total += g + 1;
        if (t == 2) exp_result = rdata;
      end
    end
  endtask

  task automatic set_plan(input int t, input int nr, input int w, input int f);
    n_rty[t] = nr;
    wt[t]    = w;
    fin[t]   = f;
  endtask

  task automatic run_measure(input int g, input bit stray);
    int n;
    model(g);
    for (int i = 0; i < 3; i++) att[i] = 0;
    obs.delete();
    done_seen = 1'b0;
    done_cnt  = 0;
    proto_bad = 0;
    gate_cycles_i = GATE_W'(g);
    start_i = 1'b1;
    e0 = cyc_n + 1;
    step();
    start_i = 1'b0;
    gate_cycles_i = GATE_W'($urandom);
    for (int k = 0; k < 3000 && !done_seen; k++) begin
      start_i = (stray && busy_o && $urandom_range(0, 5) == 0);
      step();
    end
    start_i = 1'b0;
    chk("done_seen", val_t'(done_seen), val_t'(1));
    chk("done_time", val_t'(done_cyc - e0), val_t'(exp_total));
    chk("error", val_t'(error_o), val_t'(exp_err));
    chk("result", val_t'(result_o), val_t'(exp_result));
    chk("attempt_count", val_t'(obs.size()), val_t'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("attempt_desc", obs[i], exp_q[i]);
    step();
    chk("busy_after_done", val_t'(busy_o), val_t'(0));
    chk("done_one_cycle", val_t'(done_o), val_t'(0));
    chk("done_count", val_t'(done_cnt), val_t'(1));
    chk("bus_protocol", val_t'(proto_bad), val_t'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus"}, val_t'({stb_o, cyc_o, we_o, lock_o, tagn_o, sel_o}), val_t'(0));
    chk({tag, "_adr"}, val_t'(adr_o), val_t'(0));
    chk({tag, "_dat"}, val_t'(dat_o), val_t'(0));
    chk({tag, "_busy_done"}, val_t'({busy_o, done_o}), val_t'(0));
    chk({tag, "_result"}, val_t'(result_o), val_t'(0));
    chk({tag, "_error"}, val_t'(error_o), val_t'(0));
  endtask

  task automatic plan_ok();
    for (int t = 0; t < 3; t++) set_plan(t, 0, 0, R_ACK);
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    gate_cycles_i = '0;
    dat_i = 32'h0;
    ack_i = 1'b0;
    err_i = 1'b0;
    rty_i = 1'b0;
    prev_stb = 1'b0;
    wcnt = 0;
    exp_result = 32'h0;
    plan_ok();
    rdata = 32'h0;
    repeat (3) step();
    chk_reset_outputs("reset");
    rst_i = 1'b0;
    step();

    // zero-wait slave, G=100
    plan_ok();
    rdata = 32'h0000_1234;
    run_measure(100, 1'b0);
    chk("g100_done_edge", val_t'(done_cyc - e0), val_t'(106));
    chk("g100_result", val_t'(result_o), val_t'(32'h1234));

    // silent slave on the read: timeout, result preserved
    plan_ok();
    set_plan(2, 0, 0, R_NONE);
    rdata = 32'hDEAD_0001;
    run_measure(5, 1'b0);
    chk("timeout_code", val_t'(error_o), val_t'(2'b11));
    chk("timeout_result_kept", val_t'(result_o), val_t'(32'h1234));

    // err and ack together on the read: bus error wins
    plan_ok();
    set_plan(2, 0, 0, R_ERRACK);
    rdata = 32'hBEEF_0002;
    run_measure(0, 1'b0);
    chk("err_ack_code", val_t'(error_o), val_t'(2'b01));
    chk("err_ack_result_kept", val_t'(result_o), val_t'(32'h1234));

    // two retries on the start write, then ack
    plan_ok();
    set_plan(1, 2, 0, R_ACK);
    rdata = 32'h0000_5678;
    run_measure(3, 1'b0);
    chk("retry2_attempts", val_t'(obs.size()), val_t'(5));
    chk("retry2_code", val_t'(error_o), val_t'(0));

    // retry held forever on the reset write
    plan_ok();
    set_plan(0, 100, 0, R_ACK);
    run_measure(3, 1'b0);
    chk("retry_exhaust_attempts", val_t'(obs.size()), val_t'(4));
    chk("retry_exhaust_code", val_t'(error_o), val_t'(2'b10));

    // start pulses while busy are ignored
    plan_ok();
    rdata = 32'h0BAD_CAFE;
    run_measure(20, 1'b1);

    // reset in the middle of the gate wait
    plan_ok();
    done_cnt = 0;
    for (int i = 0; i < 3; i++) att[i] = 0;
    gate_cycles_i = GATE_W'(50);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (7) step();
    chk("gate_busy", val_t'(busy_o), val_t'(1));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_reset_outputs("mid_reset");
    exp_result = 32'h0;
    repeat (80) step();
    chk("no_done_after_reset", val_t'(done_cnt), val_t'(0));

    // randomized measurements
    for (int r = 0; r < 40; r++) begin
      int g;
      int sel;
      g = $urandom_range(0, 30);
      rdata = $urandom;
      for (int t = 0; t < 3; t++) begin
        n_rty[t] = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 5) : 0;
        wt[t]    = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
        sel      = $urandom_range(0, 19);
        fin[t]   = (sel == 16) ? R_ERR : (sel == 17) ? R_ERRACK : (sel == 18) ? R_NONE : R_ACK;
      end
      run_measure(g, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/freq_count_wb_master.md
# freq_count_wb_master

Wishbone single-transfer initiator that drives the `frequency_counter` slave through one complete measurement. On a host request it:
- writes the counter-reset command;
- writes the start command;
- waits a programmable gate time;
- reads the 32-bit result.

It sits between a host/control FSM and the counter's Wishbone slave port, and reports bus errors, retry exhaustion and timeouts.

## Interface
Parameters:
- `ADDR_CTRL`, 32'h8, control register address
- `ADDR_RESULT`, 32'h9, result register address
- `GATE_W`, 16, width of gate-time count
- `TIMEOUT`, 16, max cycles a transfer may wait for ack/err/rty
- `MAX_RETRY`, 3, max `rty_i` reissues per transfer

Ports:
- `clk_i`  in  1  single clock, all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  one-cycle measurement request
- `gate_cycles_i`  in  `GATE_W`  gate wait in `clk_i` cycles, latched on accepted start
- `busy_o`  out  1  measurement in progress
- `done_o`  out  1  one-cycle pulse, result or error valid
- `result_o`  out  32  last read result
- `error_o`  out  2  00 ok, 01 bus error, 10 retries exhausted, 11 timeout
- `adr_o`  out  32  Wishbone address
- `dat_o`  out  32  Wishbone write data
- `dat_i`  in  32  Wishbone read data
- `we_o`, `cyc_o`, `stb_o`, `lock_o`  out  1  Wishbone controls; `lock_o` always 0
- `sel_o`  out  4  byte select, 4'hF during a cycle, else 0
- `ack_i`, `err_i`, `rty_i`  in  1  slave terminations
- `tagn_o`  out  1  tied 0

## Operation
- States:
  - `IDLE`
  - `WR_RST`: write data 32'h01, bit0 = counter reset
  - `GAP1`
  - `WR_START`: write data 32'h80, bit7 = start
  - `GAP2`
  - `WAIT_GATE`
  - `RD_RES`: read from `ADDR_RESULT`
  - `FINISH`
- `IDLE`: `start_i` = 1 latches `gate_cycles_i`, clears `error_o`, and goes to `WR_RST`. `start_i` is ignored in every other state.
- Transfer states drive `cyc_o`=`stb_o`=1 with the address, data and `we_o` of that step.
- Termination priority when several inputs are high together: `err_i` > `rty_i` > `ack_i`.
  - `ack_i`: advance to the next state.
  - `err_i`: `error_o`=01, go to `FINISH`.
  - `rty_i`: one idle cycle with `stb_o`=`cyc_o`=0, then reissue the identical transfer.
  - After `MAX_RETRY` reissues, a further `rty_i` sets `error_o`=10 and goes to `FINISH`.
- Each transfer has a wait counter, cleared on entry and on every reissue. `TIMEOUT` cycles without a termination sets `error_o`=11 and goes to `FINISH`.
- `GAP1`/`GAP2`: one cycle with `cyc_o`=`stb_o`=0. Back-to-back writes are never merged.
- `WAIT_GATE`: down-counter loaded with the latched gate value, exits at 0. A latched value of 0 means read immediately.
- `RD_RES` on `ack_i`: capture `dat_i` into `result_o`.
- `FINISH`: `done_o`=1 for one cycle, then `IDLE`. `result_o` holds until the next successful read and is not updated on error.
- `busy_o` = 1 in every state except `IDLE`.

## Timing
- All outputs are registered.
- Reset values: `cyc_o`, `stb_o`, `we_o`, `lock_o`, `tagn_o`, `busy_o`, `done_o` = 0; `sel_o`, `adr_o`, `dat_o`, `result_o`, `error_o` = 0; state `IDLE`.
- `start_i` sampled at edge E0: `stb_o` is high from E0 on.
- The slave's termination is sampled at each edge while `stb_o` = 1. `stb_o` drops at that same edge (the one that registers the termination), so exactly one transfer occurs per termination.
- Zero-wait-state slave, gate G:
  - write, gap, write, gap: 4 cycles;
  - gate wait: G + 1 cycles;
  - read: 1 cycle;
  - `done_o` asserts at edge E0 + G + 6.
- `rst_i` mid-operation: at the next edge all bus outputs go low, the state returns to `IDLE`, and no `done_o` is produced.

## Structure
- Package `freq_count_pkg`:
  - `ADDR_CTRL` and `ADDR_RESULT` defaults;
  - control bit positions `CTRL_RST`=0 and `CTRL_START`=7;
  - state encoding;
  - error codes.
- One sub-module, `wb_single_xfer`. It takes a request plus address/data/we and returns done, read data and error code, and owns the timeout and retry counters. The top FSM sequences three instances of its use.

## Test plan
- Zero-wait slave that acks immediately, G=100, result 32'h0000_1234: two writes, 32'h01 then 32'h80, to 32'h8; read from 32'h9. Required: `done_o` at E0+106, `result_o`=32'h1234, `error_o`=00.
- Slave asserts `rty_i` twice on `WR_START`, then acks: two idle gaps seen, three identical write cycles, `error_o`=00.
- `rty_i` held permanently with `MAX_RETRY`=3: four attempts total, then `done_o` with `error_o`=10, `busy_o` low next cycle.
- Slave never responds, `TIMEOUT`=16: `stb_o` high for 16 cycles, then `done_o` with `error_o`=11, and `result_o` still holds its previous value.
- `err_i` on `RD_RES` together with `ack_i`: `error_o`=01 (err wins) and `result_o` unchanged. Separately, `rst_i` pulsed during `WAIT_GATE`: all outputs at reset values next cycle, no `done_o`.
- `start_i` pulsed while `busy_o`=1: ignored, only one measurement sequence on the bus.
